// File: rtl/trap_clint.sv
// trap_clint: machine-mode trap sequencer sitting beside the Ex stage.
// On ecall/ebreak (or timer interrupt) it stalls the pipeline, writes mepc, mcause and mstatus
// one CSR per cycle, then redirects the PC to mtvec. On mret it restores mstatus and jumps to mepc.
//
// Ports:
//   Clk, Rst                  clock; synchronous active-low reset
//   InstPcIn                  PC of the instruction in Ex
//   EcallIn/EbreakIn/MretIn   decoded system instructions valid in Ex
//   TimerIrqIn                level timer interrupt (only with CLINT_TIMER_IRQ_EN)
//   CsrMstatusIn/MtvecIn/MepcIn  live CSR values from the CSR file
//   CsrWriteEnableClintOut / CsrWriteAddrClintOut / CsrWriteDataClintOut  CSR write port
//   HoldPipeOut               stalls every pipeline stage
//   JumpFlagOut / JumpAddrOut one-cycle PC redirect
//
// Build option: define CLINT_TIMER_IRQ_EN to add the TimerIrqIn port and interrupt handling.
module trap_clint (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [63:0] InstPcIn,
  input  logic        EcallIn,
  input  logic        EbreakIn,
  input  logic        MretIn,
`ifdef CLINT_TIMER_IRQ_EN
  input  logic        TimerIrqIn,
`endif
  input  logic [63:0] CsrMstatusIn,
  input  logic [63:0] CsrMtvecIn,
  input  logic [63:0] CsrMepcIn,
  output logic [63:0] CsrWriteDataClintOut,
  output logic [11:0] CsrWriteAddrClintOut,
  output logic        CsrWriteEnableClintOut,
  output logic        HoldPipeOut,
  output logic        JumpFlagOut,
  output logic [63:0] JumpAddrOut
);

  localparam logic [11:0] AddrMstatus = 12'h300;
  localparam logic [11:0] AddrMepc    = 12'h341;
  localparam logic [11:0] AddrMcause  = 12'h342;

  localparam logic [63:0] CauseEcall  = 64'd11;
  localparam logic [63:0] CauseEbreak = 64'd3;
  localparam logic [63:0] CauseTimer  = 64'h8000_0000_0000_0007;

  typedef enum logic [2:0] {
    StIdle, StWMepc, StWMcause, StWMstatus, StRMstatus, StJump
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] cause_q, cause_d;
  logic        mret_q, mret_d;

  logic sync_evt;
  logic timer_take;
  logic accept;

  assign sync_evt = EcallIn | EbreakIn | MretIn;

`ifdef CLINT_TIMER_IRQ_EN
  // Interrupt only wins when globally enabled and no synchronous event competes.
  assign timer_take = TimerIrqIn & CsrMstatusIn[3] & ~sync_evt;
`else
  assign timer_take = 1'b0;
`endif

  // Reset masks acceptance so nothing starts in the reset cycle.
  assign accept = Rst && (state_q == StIdle) && (sync_evt || timer_take);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    mret_d  = mret_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          pc_d = InstPcIn;
          if (EcallIn) begin
            state_d = StWMepc;
            cause_d = CauseEcall;
            mret_d  = 1'b0;
          end else if (EbreakIn) begin
            state_d = StWMepc;
            cause_d = CauseEbreak;
            mret_d  = 1'b0;
          end else if (MretIn) begin
            state_d = StRMstatus;
            mret_d  = 1'b1;
          end else begin
            state_d = StWMepc;
            cause_d = CauseTimer;
            mret_d  = 1'b0;
          end
        end
      end
      StWMepc:    state_d = StWMcause;
      StWMcause:  state_d = StWMstatus;
      StWMstatus: state_d = StJump;
      StRMstatus: state_d = StJump;
      StJump:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  // mstatus images are built from the live CSR value so a write retiring in Wb is honoured.
  logic [63:0] mstatus_trap;
  logic [63:0] mstatus_mret;

  always_comb begin
    mstatus_trap        = CsrMstatusIn;
    mstatus_trap[7]     = CsrMstatusIn[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_mret        = CsrMstatusIn;
    mstatus_mret[3]     = CsrMstatusIn[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;
  end

  always_comb begin
    CsrWriteEnableClintOut = 1'b0;
    CsrWriteAddrClintOut   = '0;
    CsrWriteDataClintOut   = '0;
    HoldPipeOut            = 1'b0;
    JumpFlagOut            = 1'b0;
    JumpAddrOut            = '0;
    case (state_q)
      StIdle: HoldPipeOut = accept;
      StWMepc: begin
        HoldPipeOut            = 1'b1;
        CsrWriteEnableClintOut = 1'b1;
        CsrWriteAddrClintOut   = AddrMepc;
        CsrWriteDataClintOut   = pc_q;
      end
      StWMcause: begin
        HoldPipeOut            = 1'b1;
        CsrWriteEnableClintOut = 1'b1;
        CsrWriteAddrClintOut   = AddrMcause;
        CsrWriteDataClintOut   = cause_q;
      end
      StWMstatus: begin
        HoldPipeOut            = 1'b1;
        CsrWriteEnableClintOut = 1'b1;
        CsrWriteAddrClintOut   = AddrMstatus;
        CsrWriteDataClintOut   = mstatus_trap;
      end
      StRMstatus: begin
        HoldPipeOut            = 1'b1;
        CsrWriteEnableClintOut = 1'b1;
        CsrWriteAddrClintOut   = AddrMstatus;
        CsrWriteDataClintOut   = mstatus_mret;
      end
      StJump: begin
        HoldPipeOut = 1'b1;
        JumpFlagOut = 1'b1;
        JumpAddrOut = mret_q ? CsrMepcIn : {CsrMtvecIn[63:2], 2'b00};
      end
      default: ;
    endcase
    // Outputs stay quiet for the whole reset cycle, even mid-sequence.
    if (!Rst) begin
      CsrWriteEnableClintOut = 1'b0;
      CsrWriteAddrClintOut   = '0;
      CsrWriteDataClintOut   = '0;
      HoldPipeOut            = 1'b0;
      JumpFlagOut            = 1'b0;
      JumpAddrOut            = '0;
    end
  end

endmodule

// File: tb/tb_trap_clint.sv
// Directed bench for trap_clint: reset, ecall, ebreak, mret, priority, mid-sequence reset,
// and timer interrupt scenarios when CLINT_TIMER_IRQ_EN is defined.
module tb_trap_clint;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [63:0] InstPcIn;
  logic        EcallIn, EbreakIn, MretIn, TimerIrqIn;
  logic [63:0] CsrMstatusIn, CsrMtvecIn, CsrMepcIn;
  logic [63:0] CsrWriteDataClintOut;
  logic [11:0] CsrWriteAddrClintOut;
  logic        CsrWriteEnableClintOut, HoldPipeOut, JumpFlagOut;
  logic [63:0] JumpAddrOut;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  trap_clint dut (
    .Clk                    (Clk),
    .Rst                    (Rst),
    .InstPcIn               (InstPcIn),
    .EcallIn                (EcallIn),
    .EbreakIn               (EbreakIn),
    .MretIn                 (MretIn),
`ifdef CLINT_TIMER_IRQ_EN
    .TimerIrqIn             (TimerIrqIn),
`endif
    .CsrMstatusIn           (CsrMstatusIn),
    .CsrMtvecIn             (CsrMtvecIn),
    .CsrMepcIn              (CsrMepcIn),
    .CsrWriteDataClintOut   (CsrWriteDataClintOut),
    .CsrWriteAddrClintOut   (CsrWriteAddrClintOut),
    .CsrWriteEnableClintOut (CsrWriteEnableClintOut),
    .HoldPipeOut            (HoldPipeOut),
    .JumpFlagOut            (JumpFlagOut),
    .JumpAddrOut            (JumpAddrOut)
  );

  // Observed outputs packed: {we, addr, data, hold, jflag, jaddr}.
  logic [142:0] obs;
  assign obs = {CsrWriteEnableClintOut, CsrWriteAddrClintOut, CsrWriteDataClintOut,
                HoldPipeOut, JumpFlagOut, JumpAddrOut};

  function automatic logic [142:0] pk(input logic we, input logic [11:0] a,
                                      input logic [63:0] d, input logic h,
                                      input logic jf, input logic [63:0] ja);
    return {we, a, d, h, jf, ja};
  endfunction

  localparam logic [142:0] Quiet = '0;

  task automatic clear_events();
    EcallIn = 0; EbreakIn = 0; MretIn = 0; TimerIrqIn = 0;
  endtask

  task automatic test_reset();
    logic [142:0] ex;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      Rst     = (c == 2);
      EcallIn = (c < 2);  // ignored while in reset
      if (c == 2) EcallIn = 0;
      #1;
      ex = Quiet;
      n_cmp++;
      if (obs !== ex) begin
        n_err++;
        $display("FAIL reset c%0d: got %h want %h", c, obs, ex);
      end
    end
  endtask

  task automatic test_ecall();
    logic [142:0] ex [6];
    ex = '{pk(0, 12'h0, 64'h0, 1, 0, 64'h0),
           pk(1, 12'h341, 64'h8000_0010, 1, 0, 64'h0),
           pk(1, 12'h342, 64'd11, 1, 0, 64'h0),
           pk(1, 12'h300, 64'h1880, 1, 0, 64'h0),
           pk(0, 12'h0, 64'h0, 1, 1, 64'h8000_1000),
           Quiet};
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      case (c)
        0: begin
          InstPcIn = 64'h8000_0010; CsrMtvecIn = 64'h8000_1001; CsrMstatusIn = 64'h8;
          EcallIn = 1;
        end
        1: EcallIn = 0;
        2: MretIn = 1;   // must be ignored while busy
        4: MretIn = 0;
        default: ;
      endcase
      #1;
      n_cmp++;
      if (obs !== ex[c]) begin
        n_err++;
        $display("FAIL ecall c%0d: got %h want %h", c, obs, ex[c]);
      end
    end
  endtask

  // mstatus and mtvec change after acceptance; the late values must be used.
  task automatic test_ebreak_late_csr();
    logic [142:0] ex [6];
    ex = '{pk(0, 12'h0, 64'h0, 1, 0, 64'h0),
           pk(1, 12'h341, 64'h100, 1, 0, 64'h0),
           pk(1, 12'h342, 64'd3, 1, 0, 64'h0),
           pk(1, 12'h300, 64'h1800, 1, 0, 64'h0),
           pk(0, 12'h0, 64'h0, 1, 1, 64'h2000),
           Quiet};
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      case (c)
        0: begin
          InstPcIn = 64'h100; CsrMstatusIn = 64'h8; CsrMtvecIn = 64'h4000; EbreakIn = 1;
        end
        1: EbreakIn = 0;
        2: CsrMstatusIn = 64'h0;
        3: CsrMtvecIn = 64'h2003;
        default: ;
      endcase
      #1;
      n_cmp++;
      if (obs !== ex[c]) begin
        n_err++;
        $display("FAIL ebreak c%0d: got %h want %h", c, obs, ex[c]);
      end
    end
  endtask

  task automatic test_mret();
    logic [142:0] ex [4];
    ex = '{pk(0, 12'h0, 64'h0, 1, 0, 64'h0),
           pk(1, 12'h300, 64'h1888, 1, 0, 64'h0),
           pk(0, 12'h0, 64'h0, 1, 1, 64'h8000_0014),
           Quiet};
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      case (c)
        0: begin
          CsrMstatusIn = 64'h1880; CsrMepcIn = 64'h8000_0014; CsrMtvecIn = 64'h9000;
          MretIn = 1;
        end
        1: MretIn = 0;
        default: ;
      endcase
      #1;
      n_cmp++;
      if (obs !== ex[c]) begin
        n_err++;
        $display("FAIL mret c%0d: got %h want %h", c, obs, ex[c]);
      end
    end
  endtask

  // All three at once takes ecall; ebreak+mret takes ebreak. Check the mcause cycle.
  task automatic test_priority();
    logic [63:0] want;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      InstPcIn = 64'h40; CsrMstatusIn = 64'h0; CsrMtvecIn = 64'h200;
      EcallIn = (k == 0); EbreakIn = 1; MretIn = 1;
      @(negedge Clk);
      clear_events();
      @(negedge Clk);
      #1;
      want = (k == 0) ? 64'd11 : 64'd3;
      n_cmp++;
      if (obs !== pk(1, 12'h342, want, 1, 0, 64'h0)) begin
        n_err++;
        $display("FAIL priority k%0d: got %h want %h", k, obs, pk(1, 12'h342, want, 1, 0, 64'h0));
      end
      repeat (3) @(negedge Clk);  // W_MSTATUS, JUMP, back to idle
    end
  endtask

  task automatic test_reset_mid();
    logic [142:0] ex [5];
    ex = '{pk(0, 12'h0, 64'h0, 1, 0, 64'h0),
           pk(1, 12'h341, 64'h500, 1, 0, 64'h0),
           Quiet, Quiet, Quiet};
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      case (c)
        0: begin InstPcIn = 64'h500; CsrMstatusIn = 64'h8; CsrMtvecIn = 64'h700; EcallIn = 1; end
        1: EcallIn = 0;
        2: Rst = 0;  // lands in W_MCAUSE
        3: Rst = 1;
        default: ;
      endcase
      #1;
      n_cmp++;
      if (obs !== ex[c]) begin
        n_err++;
        $display("FAIL reset_mid c%0d: got %h want %h", c, obs, ex[c]);
      end
    end
  endtask

`ifdef CLINT_TIMER_IRQ_EN
  task automatic test_timer();
    @(negedge Clk);
    InstPcIn = 64'h60; CsrMstatusIn = 64'h0; CsrMtvecIn = 64'h800; TimerIrqIn = 1;
    #1;
    n_cmp++;
    if (obs !== Quiet) begin
      n_err++;
      $display("FAIL timer_masked: got %h want %h", obs, Quiet);
    end
    @(negedge Clk);
    CsrMstatusIn = 64'h8;
    #1;
    n_cmp++;
    if (obs !== pk(0, 12'h0, 64'h0, 1, 0, 64'h0)) begin
      n_err++;
      $display("FAIL timer_accept: got %h want hold only", obs);
    end
    @(negedge Clk);
    TimerIrqIn = 0;
    @(negedge Clk);
    #1;
    n_cmp++;
    if (obs !== pk(1, 12'h342, 64'h8000_0000_0000_0007, 1, 0, 64'h0)) begin
      n_err++;
      $display("FAIL timer_cause: got %h want mcause 8000000000000007", obs);
    end
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_timer_vs_ecall();
    @(negedge Clk);
    InstPcIn = 64'h70; CsrMstatusIn = 64'h8; CsrMtvecIn = 64'h800;
    EcallIn = 1; TimerIrqIn = 1;
    @(negedge Clk);
    EcallIn = 0;
    @(negedge Clk);
    #1;
    n_cmp++;
    if (obs !== pk(1, 12'h342, 64'd11, 1, 0, 64'h0)) begin
      n_err++;
      $display("FAIL timer_vs_ecall: got %h want mcause 11", obs);
    end
    repeat (2) @(negedge Clk);  // W_MSTATUS, JUMP
    TimerIrqIn = 0;
    @(negedge Clk);
    #1;
    n_cmp++;
    if (obs !== Quiet) begin
      n_err++;
      $display("FAIL timer_vs_ecall_idle: got %h want %h", obs, Quiet);
    end
  endtask
`endif

  initial begin
    Rst = 0; InstPcIn = 0; CsrMstatusIn = 0; CsrMtvecIn = 0; CsrMepcIn = 0;
    clear_events();
    test_reset();
    test_ecall();
    test_ebreak_late_csr();
    test_mret();
    test_priority();
    test_reset_mid();
`ifdef CLINT_TIMER_IRQ_EN
    test_timer();
    test_timer_vs_ecall();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
